// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline controller for the five-stage RISC-V core.
// Owns the fetch PC and arbitrates stall/redirect/trap requests from ID, EX
// and MEM into per-register hold (stall_o) and bubble (flush_o) vectors.
// Also sequences the post-reset boot window, runs a stall watchdog and keeps
// bubble/redirect performance counters.
//
// Ports:
//   clk_i            core clock, all state on posedge
//   rst_n_i          synchronous active-low reset
//   id_stall_req_i   load-use hazard in ID
//   ex_stall_req_i   multi-cycle EX unit busy
//   mem_stall_req_i  data bus wait in MEM
//   ex_jump_i        taken branch/jump resolved in EX, target ex_jump_addr_i
//   trap_i           exception in MEM, handler at trap_vec_i
//   pc_o             registered fetch address
//   stall_o/flush_o  [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB
//   hang_o           sticky watchdog flag
//   bubble_cnt_o     cycles with any flush bit set
//   redirect_cnt_o   accepted jumps plus traps
module pipe_ctrl #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int unsigned     BOOT_CYCLES = 2,
    parameter int unsigned     WDT_LIMIT   = 255
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            id_stall_req_i,
    input  logic            ex_stall_req_i,
    input  logic            mem_stall_req_i,
    input  logic            ex_jump_i,
    input  logic [XLEN-1:0] ex_jump_addr_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vec_i,
    output logic [XLEN-1:0] pc_o,
    output logic [4:0]      stall_o,
    output logic [4:0]      flush_o,
    output logic            hang_o,
    output logic [31:0]     bubble_cnt_o,
    output logic [31:0]     redirect_cnt_o
);

    typedef enum logic {
        BOOT,
        RUN
    } state_t;

    localparam logic [3:0]  BOOT_LAST = 4'(BOOT_CYCLES - 1);
    localparam logic [15:0] WDT_MAX   = 16'(WDT_LIMIT);

    state_t          state;
    state_t          state_next;
    logic [3:0]      boot_cnt;
    logic [15:0]     wdt_cnt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic            hang;
    logic            redirect;
    logic [31:0]     bubble_cnt;
    logic [31:0]     redirect_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Defaults are the boot pattern, which also covers the reset cycle.
    always_comb begin
        state_next = state;
        stall_o    = 5'b00001;
        flush_o    = 5'b11110;
        pc_next    = pc;
        redirect   = 1'b0;
        if (rst_n_i) begin
            unique case (state)
                BOOT: begin
                    pc_next = RESET_PC;
                    if (boot_cnt == BOOT_LAST) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    // Jumps under an EX/MEM stall are dropped, not latched:
                    // EX re-asserts them once the stall clears.
                    if (trap_i) begin
                        stall_o  = 5'b00000;
                        flush_o  = 5'b11110;
                        pc_next  = trap_vec_i;
                        redirect = 1'b1;
                    end else if (mem_stall_req_i) begin
                        stall_o = 5'b01111;
                        flush_o = 5'b10000;
                    end else if (ex_stall_req_i) begin
                        stall_o = 5'b00111;
                        flush_o = 5'b01000;
                    end else if (ex_jump_i) begin
                        stall_o  = 5'b00000;
                        flush_o  = 5'b00110;
                        pc_next  = ex_jump_addr_i;
                        redirect = 1'b1;
                    end else if (id_stall_req_i) begin
                        stall_o = 5'b00011;
                        flush_o = 5'b00100;
                    end else begin
                        stall_o = 5'b00000;
                        flush_o = 5'b00000;
                        pc_next = pc + XLEN'(4);
                    end
                end
                default: state_next = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pc           <= RESET_PC;
            boot_cnt     <= '0;
            wdt_cnt      <= '0;
            hang         <= 1'b0;
            bubble_cnt   <= '0;
            redirect_cnt <= '0;
        end else begin
            pc <= pc_next;
            if (state == BOOT) begin
                boot_cnt <= boot_cnt + 4'd1;
            end
            if (flush_o != '0) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
            if (redirect) begin
                redirect_cnt <= redirect_cnt + 32'd1;
            end
            // hang rises on the same edge the count reaches the limit
            if (state == RUN) begin
                if (stall_o[0]) begin
                    if (wdt_cnt != WDT_MAX) begin
                        wdt_cnt <= wdt_cnt + 16'd1;
                    end
                    if (wdt_cnt >= WDT_MAX - 16'd1) begin
                        hang <= 1'b1;
                    end
                end else begin
                    wdt_cnt <= '0;
                end
            end
        end
    end

    assign pc_o           = pc;
    assign hang_o         = hang;
    assign bubble_cnt_o   = bubble_cnt;
    assign redirect_cnt_o = redirect_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed plus randomized bench for pipe_ctrl, checked against
// a cycle-level reference model of the controller rules (priority list, boot
// window, watchdog, counters). BOOT_CYCLES=2, WDT_LIMIT=4, RESET_PC=0.
module tb_pipe_ctrl;

    localparam int unsigned BOOTN = 2;
    localparam int unsigned LIM   = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_s = 1'b0, ex_s = 1'b0, mem_s = 1'b0, jmp = 1'b0, trap = 1'b0;
    logic [31:0] jaddr = '0, tvec = '0;
    logic [31:0] pc_o;
    logic [4:0]  stall_o, flush_o;
    logic        hang_o;
    logic [31:0] bubble_cnt_o, redirect_cnt_o;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    // reference model state
    logic        m_valid = 1'b0;
    logic [31:0] m_pc, m_bub, m_red;
    int          m_boot_left, m_wdt;
    logic        m_hang;

    pipe_ctrl #(
        .XLEN(32),
        .RESET_PC(RPC),
        .BOOT_CYCLES(BOOTN),
        .WDT_LIMIT(LIM)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .id_stall_req_i(id_s),
        .ex_stall_req_i(ex_s),
        .mem_stall_req_i(mem_s),
        .ex_jump_i(jmp),
        .ex_jump_addr_i(jaddr),
        .trap_i(trap),
        .trap_vec_i(tvec),
        .pc_o(pc_o),
        .stall_o(stall_o),
        .flush_o(flush_o),
        .hang_o(hang_o),
        .bubble_cnt_o(bubble_cnt_o),
        .redirect_cnt_o(redirect_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set(input logic r, input logic t, input logic m, input logic e,
                       input logic j, input logic i, input logic [31:0] ja,
                       input logic [31:0] tv);
        rst_n = r; trap = t; mem_s = m; ex_s = e; jmp = j; id_s = i;
        jaddr = ja; tvec = tv;
    endtask

    // Compare DUT against the model for the current cycle, advance the model,
    // then move to the next negedge where new inputs get applied.
    task automatic cycle();
        logic [4:0]  es, ef;
        logic [31:0] npc;
        logic        red;
        #1;
        npc = m_pc;
        red = 1'b0;
        if (!rst_n || m_boot_left > 0) begin es = 5'b00001; ef = 5'b11110; end
        else if (trap)  begin es = 5'b00000; ef = 5'b11110; npc = tvec; red = 1'b1; end
        else if (mem_s) begin es = 5'b01111; ef = 5'b10000; end
        else if (ex_s)  begin es = 5'b00111; ef = 5'b01000; end
        else if (jmp)   begin es = 5'b00000; ef = 5'b00110; npc = jaddr; red = 1'b1; end
        else if (id_s)  begin es = 5'b00011; ef = 5'b00100; end
        else            begin es = 5'b00000; ef = 5'b00000; npc = m_pc + 32'd4; end
        chk("stall_o", {27'b0, stall_o}, {27'b0, es});
        chk("flush_o", {27'b0, flush_o}, {27'b0, ef});
        if (m_valid) begin
            chk("pc_o", pc_o, m_pc);
            chk("hang_o", {31'b0, hang_o}, {31'b0, m_hang});
            chk("bubble_cnt_o", bubble_cnt_o, m_bub);
            chk("redirect_cnt_o", redirect_cnt_o, m_red);
        end
        if (!rst_n) begin
            m_pc = RPC; m_boot_left = BOOTN; m_wdt = 0; m_hang = 1'b0;
            m_bub = '0; m_red = '0; m_valid = 1'b1;
        end else begin
            if (ef != 5'b0) m_bub = m_bub + 32'd1;
            if (m_boot_left > 0) begin
                m_boot_left--;
                m_pc = RPC;
            end else begin
                if (red) m_red = m_red + 32'd1;
                m_pc = npc;
                if (es[0]) begin
                    if (m_wdt < LIM) m_wdt++;
                    if (m_wdt >= LIM) m_hang = 1'b1;
                end else begin
                    m_wdt = 0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] exp_pc [5];
        logic [31:0] r0, p;
        exp_pc = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h8};

        @(negedge clk);
        // reset, then boot window
        set(0, 0, 0, 0, 0, 0, '0, '0);
        cycle();
        cycle();
        set(1, 0, 0, 0, 0, 0, '0, '0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("boot_pc_seq", pc_o, exp_pc[i]);
            chk("boot_flush", {27'b0, flush_o}, (i < 2) ? 32'h1E : 32'h0);
            cycle();
        end
        chk("boot_bubbles", bubble_cnt_o, 32'd2);

        // jump at pc 0x20
        for (int i = 0; i < 64; i++) begin
            if (pc_o == 32'h20) break;
            cycle();
        end
        chk("reach_pc20", pc_o, 32'h20);
        r0 = m_red;
        set(1, 0, 0, 0, 1, 0, 32'h100, '0);
        #1;
        chk("jump_flush", {27'b0, flush_o}, 32'h06);
        cycle();
        set(1, 0, 0, 0, 0, 0, '0, '0);
        chk("jump_pc", pc_o, 32'h100);
        cycle();
        chk("jump_pc4", pc_o, 32'h104);
        chk("jump_redirect", redirect_cnt_o, r0 + 32'd1);

        // priority: trap beats mem stall and jump
        set(1, 1, 1, 0, 1, 0, 32'h200, 32'h80);
        #1;
        chk("prio_flush", {27'b0, flush_o}, 32'h1E);
        chk("prio_stall", {27'b0, stall_o}, 32'h0);
        cycle();
        set(1, 0, 0, 0, 0, 0, '0, '0);
        chk("prio_pc", pc_o, 32'h80);
        cycle();

        // watchdog: 3 stalls then a free cycle never trips
        for (int k = 0; k < 3; k++) begin
            set(1, 0, 0, 0, 0, 1, '0, '0);
            repeat (3) cycle();
            set(1, 0, 0, 0, 0, 0, '0, '0);
            cycle();
        end
        chk("wdt_nohang", {31'b0, hang_o}, 32'h0);

        // watchdog: 4 consecutive stalls trip, flag is sticky
        set(1, 0, 0, 0, 0, 1, '0, '0);
        repeat (4) cycle();
        set(1, 0, 0, 0, 0, 0, '0, '0);
        chk("wdt_hang", {31'b0, hang_o}, 32'h1);
        cycle();
        cycle();
        chk("wdt_sticky", {31'b0, hang_o}, 32'h1);

        // stall stack
        p = m_pc;
        set(1, 0, 1, 1, 0, 1, '0, '0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stack_stall", {27'b0, stall_o}, 32'h0F);
            chk("stack_flush", {27'b0, flush_o}, 32'h10);
            chk("stack_pc", pc_o, p);
            cycle();
        end
        set(1, 0, 0, 1, 0, 1, '0, '0);
        #1;
        chk("stack_ex_stall", {27'b0, stall_o}, 32'h07);
        cycle();
        set(1, 0, 0, 0, 0, 0, '0, '0);
        cycle();

        // PC wrap
        set(1, 0, 0, 0, 1, 0, 32'hFFFF_FFFC, '0);
        cycle();
        set(1, 0, 0, 0, 0, 0, '0, '0);
        chk("wrap_pre", pc_o, 32'hFFFF_FFFC);
        cycle();
        chk("wrap_pc", pc_o, 32'h0);

        // reset wins over a trap
        set(0, 1, 0, 0, 0, 0, '0, 32'h80);
        cycle();
        set(1, 0, 0, 0, 0, 0, '0, '0);
        chk("rst_pc", pc_o, RPC);
        chk("rst_bubbles", bubble_cnt_o, 32'h0);
        chk("rst_redirects", redirect_cnt_o, 32'h0);
        chk("rst_hang", {31'b0, hang_o}, 32'h0);
        #1;
        chk("rst_boot_flush", {27'b0, flush_o}, 32'h1E);
        cycle();
        cycle();

        // randomized traffic against the model
        repeat (400) begin
            set($urandom_range(0, 63) != 0,
                $urandom_range(0, 7) == 0,
                $urandom_range(0, 4) == 0,
                $urandom_range(0, 4) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0,
                $urandom, $urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline controller for the five-stage RISC-V core. It owns the program counter that addresses the instruction ROM. Each cycle it turns stall, redirect and trap requests from the ID, EX and MEM stages into per-register stall and flush vectors for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also sequences the post-reset boot window, runs a stall watchdog and keeps bubble/flush performance counters.

## Interface
- XLEN, 32, datapath/address width (matches `XLEN).
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- BOOT_CYCLES, 2, cycles after reset release during which fetch is held (1..15).
- WDT_LIMIT, 255, consecutive stall cycles that raise hang_o (1..65535).
- clk_i  input  1  core clock; all state updates on posedge.
- rst_n_i  input  1  synchronous, active-low reset.
- id_stall_req_i  input  1  load-use hazard detected in ID.
- ex_stall_req_i  input  1  multi-cycle EX unit busy.
- mem_stall_req_i  input  1  data bus wait in MEM.
- ex_jump_i  input  1  taken branch/jump resolved in EX.
- ex_jump_addr_i  input  XLEN  jump target.
- trap_i  input  1  exception raised by the instruction in MEM.
- trap_vec_i  input  XLEN  trap handler address.
- pc_o  output  XLEN  current fetch address to ROM and to IF pc_i.
- stall_o  output  5  hold enables: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB.
- flush_o  output  5  bubble-insert enables, same bit mapping.
- hang_o  output  1  sticky watchdog flag.
- bubble_cnt_o  output  32  count of cycles with any flush_o bit set.
- redirect_cnt_o  output  32  count of accepted jumps plus traps.

## Operation
- FSM states: BOOT, RUN.
  - Reset forces BOOT.
  - BOOT lasts BOOT_CYCLES cycles, then goes to RUN.
  - RUN has no exit except reset.
- In BOOT:
  - stall_o=5'b00001, flush_o=5'b11110.
  - All request inputs are ignored.
  - PC holds RESET_PC.
- In RUN, exactly one case applies, in priority order:
  1. trap_i: stall_o=0, flush_o=5'b11110, PC<=trap_vec_i.
  2. mem_stall_req_i: stall_o=5'b01111, flush_o=5'b10000.
  3. ex_stall_req_i: stall_o=5'b00111, flush_o=5'b01000.
  4. ex_jump_i: stall_o=0, flush_o=5'b00110, PC<=ex_jump_addr_i.
  5. id_stall_req_i: stall_o=5'b00011, flush_o=5'b00100.
  6. none: stall_o=0, flush_o=0, PC<=PC+4.
- A jump that coincides with an EX or MEM stall is not accepted. EX holds and re-asserts it after the stall, so the controller does not latch a pending jump.
- An ID stall coinciding with a jump is discarded, because the stalled instruction is flushed.
- PC arithmetic:
  - PC+4 wraps modulo 2^XLEN.
  - Targets are taken verbatim, bits [1:0] included. Alignment faults are raised upstream.
- Watchdog:
  - A 16-bit counter increments on every RUN cycle with stall_o[0]=1 and clears on any RUN cycle with stall_o[0]=0.
  - When the count reaches WDT_LIMIT, hang_o is set. hang_o stays set until reset; the count saturates.
  - BOOT cycles neither count nor clear.
- Counters:
  - Both are 32-bit and wrap to 0 after 2^32-1.
  - bubble_cnt_o increments on any cycle, BOOT included, with flush_o!=0.
  - redirect_cnt_o increments on accepted traps and jumps only.

## Timing
- stall_o and flush_o are combinational from the inputs and state in the same cycle. Pipeline registers act on them at the next posedge.
- pc_o is registered. A redirect accepted in cycle N drives pc_o=target in cycle N+1, and IF/ID captures the target's instruction at the end of N+1.
- Jump penalty is 2 bubbles. Trap penalty is 4 bubbles.
- Reset values:
  - pc_o=RESET_PC, state=BOOT, watchdog count 0.
  - hang_o=0, bubble_cnt_o=0, redirect_cnt_o=0.
  - stall_o=5'b00001 and flush_o=5'b11110 in the reset cycle.
- Reset asserted mid-operation (e.g. during a trap redirect) wins over every request. The redirect is dropped and pc_o=RESET_PC on the next cycle.
- First fetch of RESET_PC reaches IF/ID at the end of cycle BOOT_CYCLES after reset release.

## Test plan
- Boot: release rst_n_i with BOOT_CYCLES=2 and no requests -> pc_o sequence 0,0,0,4,8; flush_o=5'b11110 for 2 cycles then 0; bubble_cnt_o=2.
- Jump: in RUN at pc_o=0x20, pulse ex_jump_i with addr 0x100 -> that cycle flush_o=5'b00110; next cycle pc_o=0x100, then 0x104; redirect_cnt_o+1.
- Priority: assert trap_i (vec 0x80), mem_stall_req_i and ex_jump_i (0x200) together -> flush_o=5'b11110, stall_o=0, next pc_o=0x80.
- Stall stack: hold mem_stall_req_i 3 cycles with ex_stall_req_i and id_stall_req_i also high -> stall_o=5'b01111, flush_o=5'b10000 each cycle; pc_o frozen; then drop mem only -> stall_o=5'b00111.
- Watchdog: WDT_LIMIT=4, hold id_stall_req_i 4 cycles -> hang_o=1 after the 4th, stays 1 after release; with 3 stall cycles then one free cycle, repeated -> hang_o stays 0.
- Wrap and reset: force PC to 0xFFFF_FFFC with no requests -> next pc_o=0; assert rst_n_i=0 during a trap cycle -> pc_o=RESET_PC, counters 0, state BOOT.
